operand_entry_mult_ctrl: RTL and testbench

Controller that sequences bit-serial operand entry from one push-button and one switch, then runs an unsigned shift-add multiply and holds the result for display. The board-level top drives it directly from the raw button and switch pins. Its phase and bit-index outputs drive the LED and seven-segment state indicators, and its operand and product outputs drive the display datapath.

---
 rtl/operand_entry_mult_ctrl.sv | 172 +++++++++++++++++
 tb/tb_operand_entry_mult_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_entry_mult_ctrl.sv
// operand_entry_mult_ctrl
//   Bit-serial operand entry from one push-button and one switch, followed by
//   a W-cycle unsigned shift-add multiply whose result is held for display.
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   btn      raw push-button (async, active-high)
//   bit_in   switch value captured on each accepted entry press
//   phase    0=ENT_A 1=ENT_B 2=CALC 3=SHOW
//   bit_idx  operand bit position being entered
//   a_val    operand A
//   b_val    operand B
//   product  2W-bit result, valid while phase==SHOW
//   busy     high during CALC
//   done     one-cycle pulse on the first SHOW cycle
module operand_entry_mult_ctrl #(
  parameter int unsigned W       = 4,
  parameter int unsigned LOCKOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   btn,
  input  logic                   bit_in,
  output logic [1:0]             phase,
  output logic [$clog2(W)-1:0]   bit_idx,
  output logic [W-1:0]           a_val,
  output logic [W-1:0]           b_val,
  output logic [2*W-1:0]         product,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned IW = $clog2(W);
  localparam int unsigned LW = $clog2(LOCKOUT + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(W - 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT);

  typedef enum logic [1:0] {
    ENT_A = 2'd0,
    ENT_B = 2'd1,
    CALC  = 2'd2,
    SHOW  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            s1_q, s2_q, prev_q;
  logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [IW-1:0]   bit_idx_q, bit_idx_d;
  logic [IW-1:0]   calc_cnt_q, calc_cnt_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    mplr_q, mplr_d;
  logic [2*W-1:0]  mcand_q, mcand_d;
  logic [2*W-1:0]  prod_q, prod_d;
  logic            done_q, done_d;
  logic            press;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      prev_q     <= 1'b0;
      lock_cnt_q <= '0;
      state_q    <= ENT_A;
      bit_idx_q  <= '0;
      calc_cnt_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      mplr_q     <= '0;
      mcand_q    <= '0;
      prod_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      s1_q       <= btn;
      s2_q       <= s1_q;
      prev_q     <= s2_q;
      lock_cnt_q <= lock_cnt_d;
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      calc_cnt_q <= calc_cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mplr_q     <= mplr_d;
      mcand_q    <= mcand_d;
      prod_q     <= prod_d;
      done_q     <= done_d;
    end
  end

  // Presses in CALC are swallowed entirely, so they never arm the lockout.
  assign press = s2_q & ~prev_q & (lock_cnt_q == '0) & (state_q != CALC);

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    calc_cnt_d = calc_cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    mplr_d     = mplr_q;
    mcand_d    = mcand_q;
    prod_d     = prod_q;
    done_d     = 1'b0;
    lock_cnt_d = (lock_cnt_q != '0) ? lock_cnt_q - LW'(1) : lock_cnt_q;

    if (press) begin
      lock_cnt_d = LOCK_LOAD;
    end

    case (state_q)
      ENT_A: begin
        if (press) begin
          a_d = {a_q[W-2:0], bit_in};
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d = '0;
            state_d   = ENT_B;
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
          end
        end
      end
      ENT_B: begin
        if (press) begin
          b_d = {b_q[W-2:0], bit_in};
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d  = '0;
            state_d    = CALC;
            // Multiplier is taken from the shift result, not the stale b_q.
            mplr_d     = {b_q[W-2:0], bit_in};
            mcand_d    = {{W{1'b0}}, a_q};
            prod_d     = '0;
            calc_cnt_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
          end
        end
      end
      CALC: begin
        if (mplr_q[0]) begin
          prod_d = prod_q + mcand_q;
        end
        mcand_d    = mcand_q << 1;
        mplr_d     = mplr_q >> 1;
        calc_cnt_d = calc_cnt_q + IW'(1);
        if (calc_cnt_q == LAST_IDX) begin
          state_d = SHOW;
          done_d  = 1'b1;
        end
      end
      SHOW: begin
        if (press) begin
          state_d   = ENT_A;
          a_d       = '0;
          b_d       = '0;
          prod_d    = '0;
          bit_idx_d = '0;
        end
      end
      default: begin
        state_d = ENT_A;
      end
    endcase
  end

  assign phase   = state_q;
  assign bit_idx = bit_idx_q;
  assign a_val   = a_q;
  assign b_val   = b_q;
  assign product = prod_q;
  assign busy    = (state_q == CALC);
  assign done    = done_q;

endmodule

// File: tb/tb_operand_entry_mult_ctrl.sv
module tb_operand_entry_mult_ctrl;

  localparam int unsigned W       = 4;
  localparam int unsigned LOCKOUT = 16;

  logic         clk;
  logic         rst_n;
  logic         btn;
  logic         bit_in;
  logic [1:0]   phase;
  logic [1:0]   bit_idx;
  logic [3:0]   a_val;
  logic [3:0]   b_val;
  logic [7:0]   product;
  logic         busy;
  logic         done;

  operand_entry_mult_ctrl #(
    .W(W),
    .LOCKOUT(LOCKOUT)
  ) dut (
    .clk    (clk),
    .reset  (rst_n),
    .btn    (btn),
    .bit_in (bit_in),
    .phase  (phase),
    .bit_idx(bit_idx),
    .a_val  (a_val),
    .b_val  (b_val),
    .product(product),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] p;
    logic [3:0] a;
    logic [3:0] b;
  } exp_t;

  exp_t sb[$];
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   done_seen = 0;
  int   busy_run  = 0;
  logic done_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Scoreboard consumer: every done pulse retires one expected result.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run  = 0;
      done_prev = 1'b0;
    end else begin
      if (done_prev) check_eq("done_once", {31'd0, done}, 32'd0);
      if (busy) busy_run++;
      if (done) begin
        done_seen++;
        if (sb.size() == 0) begin
          check_eq("done_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("product", {24'd0, product}, {24'd0, e.p});
          check_eq("a_val",   {28'd0, a_val},   {28'd0, e.a});
          check_eq("b_val",   {28'd0, b_val},   {28'd0, e.b});
          check_eq("phase_show", {30'd0, phase}, 32'd3);
          check_eq("busy_cycles", busy_run, W);
        end
        busy_run = 0;
      end
      done_prev = done;
    end
  end

  task automatic press(input logic b);
    bit_in = b;
    @(negedge clk);
    btn = 1'b1;
    repeat (4) @(negedge clk);
    btn = 1'b0;
    repeat (LOCKOUT + 4) @(negedge clk);
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_seen < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_timeout", {31'd0, done_seen >= target}, 32'd1);
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("busy_timeout", {31'd0, busy}, 32'd1);
  endtask

  task automatic push_exp(input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    e.p = 8'(a * b);
    sb.push_back(e);
  endtask

  task automatic enter_ops(input logic [3:0] a, input logic [3:0] b, inout int tgt);
    for (int i = 3; i >= 0; i--) press(a[i]);
    for (int i = 3; i >= 1; i--) press(b[i]);
    push_exp(a, b);
    tgt++;
    press(b[0]);
    wait_done(tgt);
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_phase"},   {30'd0, phase},   32'd0);
    check_eq({tag, "_bit_idx"}, {30'd0, bit_idx}, 32'd0);
    check_eq({tag, "_a"},       {28'd0, a_val},   32'd0);
    check_eq({tag, "_b"},       {28'd0, b_val},   32'd0);
    check_eq({tag, "_product"}, {24'd0, product}, 32'd0);
  endtask

  initial begin
    int tgt;
    int snap;
    tgt    = 0;
    rst_n  = 1'b0;
    btn    = 1'b0;
    bit_in = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    check_eq("reset_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 11 x 6
    enter_ops(4'b1011, 4'b0110, tgt);
    check_eq("show_hold", {30'd0, phase}, 32'd3);
    press(1'b0);
    check_cleared("show_exit");

    // 15 x 15, then 0 x 10
    enter_ops(4'b1111, 4'b1111, tgt);
    press(1'b0);
    enter_ops(4'b0000, 4'b1010, tgt);
    press(1'b0);
    check_eq("bounce_start", {30'd0, bit_idx}, 32'd0);

    // Bounce: three rises inside the lockout window count once.
    bit_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); btn = 1'b1;
      @(negedge clk);
      @(negedge clk); btn = 1'b0;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check_eq("bounce_once", {30'd0, bit_idx}, 32'd1);
    repeat (10) @(negedge clk);
    press(1'b1);
    check_eq("after_lock", {30'd0, bit_idx}, 32'd2);
    press(1'b0);
    press(1'b1);
    check_eq("a_entered", {28'd0, a_val}, 32'd13);
    check_eq("to_ent_b", {30'd0, phase}, 32'd1);

    // Long hold in ENT_B accepts one bit only.
    bit_in = 1'b1;
    @(negedge clk);
    btn = 1'b1;
    repeat (100) @(negedge clk);
    btn = 1'b0;
    repeat (LOCKOUT + 4) @(negedge clk);
    check_eq("hold_idx", {30'd0, bit_idx}, 32'd1);
    check_eq("hold_phase", {30'd0, phase}, 32'd1);
    press(1'b0);
    press(1'b1);

    // Final B bit, then a fresh button rise while CALC runs.
    push_exp(4'd13, 4'b1011);
    tgt++;
    bit_in = 1'b1;
    @(negedge clk);
    btn = 1'b1;
    wait_busy();
    @(negedge clk); btn = 1'b0;
    @(negedge clk); btn = 1'b1;
    wait_done(tgt);
    repeat (5) @(negedge clk);
    btn = 1'b0;
    repeat (LOCKOUT + 4) @(negedge clk);
    check_eq("calc_press_ignored", {30'd0, phase}, 32'd3);
    check_eq("calc_product_held", {24'd0, product}, 32'd143);
    press(1'b0);
    check_cleared("show_exit2");

    // Reset in the second CALC cycle aborts without a done pulse.
    for (int i = 3; i >= 0; i--) press(i < 2);
    press(1'b0);
    press(1'b1);
    press(1'b0);
    bit_in = 1'b1;
    @(negedge clk);
    btn = 1'b1;
    wait_busy();
    @(negedge clk);
    snap  = done_seen;
    rst_n = 1'b0;
    btn   = 1'b0;
    #1;
    check_cleared("abort");
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check_eq("abort_no_done", done_seen, snap);
    check_cleared("post_abort");

    // 3 x 5
    enter_ops(4'b0011, 4'b0101, tgt);
    repeat (3) @(negedge clk);
    check_eq("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
